// File: rtl/issue_pkg.sv
// Shared types and constants for the integer issue queue slots.
// Holds the slot state encoding and the branch-kill helper.
package issue_pkg;

  localparam int PREG_W    = 7;
  localparam int BR_MASK_W = 20;

  typedef enum logic [1:0] {
    S_INVALID = 2'd0,
    S_VALID_1 = 2'd1,
    S_VALID_2 = 2'd2
  } slot_state_e;

  function automatic logic br_hit(input logic [BR_MASK_W-1:0] mask,
                                  input logic [BR_MASK_W-1:0] mispredict);
    return |(mask & mispredict);
  endfunction

endpackage

// File: rtl/wakeup_match.sv
// Compares one physical register tag against every writeback wakeup port.
module wakeup_match #(
  parameter int NUM_WAKEUP = 4,
  parameter int PREG_W     = 7
) (
  input  logic [PREG_W-1:0]            tag_i,
  input  logic [NUM_WAKEUP-1:0]        valid_i,
  input  logic [NUM_WAKEUP*PREG_W-1:0] pdst_i,
  output logic                         hit_o
);

  logic [NUM_WAKEUP-1:0] port_hit;

  always_comb begin
    port_hit = '0;
    for (int i = 0; i < NUM_WAKEUP; i++) begin
      port_hit[i] = valid_i[i] && (pdst_i[i*PREG_W +: PREG_W] == tag_i);
    end
  end

  assign hit_o = |port_hit;

endmodule

// File: rtl/issue_slot_int.sv
// One integer issue-queue entry: holds a uop until its operands are ready,
// requests issue, and tracks wakeups, branch resolution and two-part uops.
module issue_slot_int
  import issue_pkg::*;
#(
  parameter int NUM_WAKEUP = 4,
  parameter int PAYLOAD_W  = 96
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic                         io_in_valid,
  input  logic                         io_in_two_part,
  input  logic [PREG_W-1:0]            io_in_prs1,
  input  logic [PREG_W-1:0]            io_in_prs2,
  input  logic [PREG_W-1:0]            io_in_pdst,
  input  logic                         io_in_prs1_busy,
  input  logic                         io_in_prs2_busy,
  input  logic [BR_MASK_W-1:0]         io_in_br_mask,
  input  logic [PAYLOAD_W-1:0]         io_in_payload,
  input  logic [NUM_WAKEUP-1:0]        io_wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] io_wakeup_pdst,
  input  logic [BR_MASK_W-1:0]         io_brupdate_resolve_mask,
  input  logic [BR_MASK_W-1:0]         io_brupdate_mispredict_mask,
  input  logic                         io_kill,
  input  logic                         io_clear,
  input  logic                         io_grant,
  output logic                         io_valid,
  output logic                         io_will_be_valid,
  output logic                         io_request,
  output logic                         io_iss_part,
  output logic [PREG_W-1:0]            io_uop_prs1,
  output logic [PREG_W-1:0]            io_uop_prs2,
  output logic [PREG_W-1:0]            io_uop_pdst,
  output logic [BR_MASK_W-1:0]         io_uop_br_mask,
  output logic [PAYLOAD_W-1:0]         io_uop_payload
);

  slot_state_e          state_q, state_d;
  logic                 p1_q, p1_d, p2_q, p2_d, part_q, part_d;
  logic [PREG_W-1:0]    prs1_q, prs1_d, prs2_q, prs2_d, pdst_q, pdst_d;
  logic [BR_MASK_W-1:0] br_mask_q, br_mask_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 wake1, wake2, mis_hit, ready, grant_ok, leaving, load_en;
  logic [PREG_W-1:0]    tag1, tag2;

  // While enqueueing, match against the incoming tags so a same-cycle wakeup is not lost.
  assign tag1 = load_en ? io_in_prs1 : prs1_q;
  assign tag2 = load_en ? io_in_prs2 : prs2_q;

  wakeup_match #(.NUM_WAKEUP(NUM_WAKEUP), .PREG_W(PREG_W)) u_wake_prs1 (
    .tag_i(tag1), .valid_i(io_wakeup_valid), .pdst_i(io_wakeup_pdst), .hit_o(wake1)
  );
  wakeup_match #(.NUM_WAKEUP(NUM_WAKEUP), .PREG_W(PREG_W)) u_wake_prs2 (
    .tag_i(tag2), .valid_i(io_wakeup_valid), .pdst_i(io_wakeup_pdst), .hit_o(wake2)
  );

  assign io_valid = (state_q != S_INVALID);
  assign mis_hit  = io_valid && br_hit(br_mask_q, io_brupdate_mispredict_mask);

  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_VALID_1: ready = part_q ? p2_q : (p1_q & p2_q);
      S_VALID_2: ready = p1_q;
      default:   ready = 1'b0;
    endcase
  end

  assign io_request       = ready & ~io_kill & ~mis_hit;
  assign grant_ok         = io_grant & io_request;
  assign leaving          = io_kill | mis_hit | io_clear | (grant_ok & (state_q == S_VALID_1));
  assign io_will_be_valid = io_valid & ~leaving;
  // A new uop is accepted only once the slot is free (or freed this cycle), never under kill.
  assign load_en          = io_in_valid & ~io_kill & ~io_will_be_valid;

  always_comb begin
    state_d   = state_q;
    part_d    = part_q;
    p1_d      = p1_q | wake1;
    p2_d      = p2_q | wake2;
    prs1_d    = prs1_q;
    prs2_d    = prs2_q;
    pdst_d    = pdst_q;
    br_mask_d = br_mask_q & ~io_brupdate_resolve_mask;
    payload_d = payload_q;
    if (leaving) begin
      state_d = S_INVALID;
    end else if (grant_ok && (state_q == S_VALID_2)) begin
      state_d = S_VALID_1;
      part_d  = 1'b1;
    end
    if (load_en) begin
      state_d   = io_in_two_part ? S_VALID_2 : S_VALID_1;
      part_d    = 1'b0;
      p1_d      = ~io_in_prs1_busy | wake1;
      p2_d      = ~io_in_prs2_busy | wake2;
      prs1_d    = io_in_prs1;
      prs2_d    = io_in_prs2;
      pdst_d    = io_in_pdst;
      br_mask_d = io_in_br_mask & ~io_brupdate_resolve_mask;
      payload_d = io_in_payload;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= S_INVALID;
      part_q    <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      prs1_q    <= '0;
      prs2_q    <= '0;
      pdst_q    <= '0;
      br_mask_q <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      part_q    <= part_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      prs1_q    <= prs1_d;
      prs2_q    <= prs2_d;
      pdst_q    <= pdst_d;
      br_mask_q <= br_mask_d;
      payload_q <= payload_d;
    end
  end

  assign io_iss_part    = part_q;
  assign io_uop_prs1    = prs1_q;
  assign io_uop_prs2    = prs2_q;
  assign io_uop_pdst    = pdst_q;
  assign io_uop_br_mask = br_mask_q & ~io_brupdate_resolve_mask;
  assign io_uop_payload = payload_q;

  // Grant is only meaningful with a request; kill/mispredict may race a grant.
  a_grant_needs_request: assert property (@(posedge clk_sys) disable iff (rst)
    io_grant |-> (io_request || io_kill || mis_hit));

endmodule

// File: tb/tb_issue_slot_int.sv
// Directed self-checking bench for issue_slot_int.
module tb_issue_slot_int;

  localparam int NW = 4;
  localparam int PW = 7;
  localparam int BW = 20;
  localparam int DW = 96;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic          io_in_valid, io_in_two_part, io_in_prs1_busy, io_in_prs2_busy;
  logic [PW-1:0] io_in_prs1, io_in_prs2, io_in_pdst;
  logic [BW-1:0] io_in_br_mask, io_brupdate_resolve_mask, io_brupdate_mispredict_mask;
  logic [DW-1:0] io_in_payload;
  logic [NW-1:0] io_wakeup_valid;
  logic [NW*PW-1:0] io_wakeup_pdst;
  logic          io_kill, io_clear, io_grant;
  logic          io_valid, io_will_be_valid, io_request, io_iss_part;
  logic [PW-1:0] io_uop_prs1, io_uop_prs2, io_uop_pdst;
  logic [BW-1:0] io_uop_br_mask;
  logic [DW-1:0] io_uop_payload;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] PAY_A = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};

  always #5 clk_sys = ~clk_sys;

  issue_slot_int #(.NUM_WAKEUP(NW), .PAYLOAD_W(DW)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .io_in_valid(io_in_valid), .io_in_two_part(io_in_two_part),
    .io_in_prs1(io_in_prs1), .io_in_prs2(io_in_prs2), .io_in_pdst(io_in_pdst),
    .io_in_prs1_busy(io_in_prs1_busy), .io_in_prs2_busy(io_in_prs2_busy),
    .io_in_br_mask(io_in_br_mask), .io_in_payload(io_in_payload),
    .io_wakeup_valid(io_wakeup_valid), .io_wakeup_pdst(io_wakeup_pdst),
    .io_brupdate_resolve_mask(io_brupdate_resolve_mask),
    .io_brupdate_mispredict_mask(io_brupdate_mispredict_mask),
    .io_kill(io_kill), .io_clear(io_clear), .io_grant(io_grant),
    .io_valid(io_valid), .io_will_be_valid(io_will_be_valid), .io_request(io_request),
    .io_iss_part(io_iss_part), .io_uop_prs1(io_uop_prs1), .io_uop_prs2(io_uop_prs2),
    .io_uop_pdst(io_uop_pdst), .io_uop_br_mask(io_uop_br_mask), .io_uop_payload(io_uop_payload)
  );

  task automatic clr_in();
    io_in_valid = 0; io_in_two_part = 0; io_in_prs1_busy = 0; io_in_prs2_busy = 0;
    io_in_prs1 = '0; io_in_prs2 = '0; io_in_pdst = '0; io_in_br_mask = '0;
    io_in_payload = '0; io_wakeup_valid = '0; io_wakeup_pdst = '0;
    io_brupdate_resolve_mask = '0; io_brupdate_mispredict_mask = '0;
    io_kill = 0; io_clear = 0; io_grant = 0;
  endtask

  task automatic enq(input logic [PW-1:0] p1, input logic [PW-1:0] p2, input logic b1,
                     input logic b2, input logic two, input logic [BW-1:0] mask);
    io_in_valid = 1; io_in_prs1 = p1; io_in_prs2 = p2; io_in_pdst = 7'd3;
    io_in_prs1_busy = b1; io_in_prs2_busy = b2; io_in_two_part = two;
    io_in_br_mask = mask; io_in_payload = PAY_A;
  endtask

  task automatic wake(input int port, input logic [PW-1:0] tag);
    io_wakeup_valid[port] = 1'b1;
    io_wakeup_pdst[port*PW +: PW] = tag;
  endtask

  // Inputs change at negedge; outputs are checked 2 time units later, well before the posedge.
  task automatic next_cycle();
    @(negedge clk_sys);
    clr_in();
  endtask

  task automatic test_reset();
    rst = 1; clr_in();
    @(negedge clk_sys); @(negedge clk_sys); #2;
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", io_valid); end
    checks++; if (io_request !== 1'b0) begin errors++; $display("FAIL reset_request got %b exp 0", io_request); end
    checks++; if (io_will_be_valid !== 1'b0) begin errors++; $display("FAIL reset_wbv got %b exp 0", io_will_be_valid); end
    checks++; if ({io_iss_part, io_uop_prs1, io_uop_prs2, io_uop_br_mask} !== '0) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {io_iss_part, io_uop_prs1, io_uop_prs2, io_uop_br_mask}); end
    rst = 0;
  endtask

  task automatic test_wakeup_seq();
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      if (c == 0) enq(7'd5, 7'd9, 1, 1, 0, '0);
      if (c == 3) wake(0, 7'd5);
      if (c == 6) wake(2, 7'd9);
      if (c == 7) io_grant = 1;
      #2;
      checks++; if (io_request !== (c == 7)) begin errors++; $display("FAIL wseq_request c=%0d got %b exp %b", c, io_request, (c == 7)); end
      checks++; if (io_valid !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL wseq_valid c=%0d got %b exp %b", c, io_valid, (c >= 1 && c <= 7)); end
      if (c == 1) begin
        checks++; if ({io_uop_prs1, io_uop_prs2, io_uop_pdst} !== {7'd5, 7'd9, 7'd3}) begin
          errors++; $display("FAIL wseq_regs got %h exp %h", {io_uop_prs1, io_uop_prs2, io_uop_pdst}, {7'd5, 7'd9, 7'd3}); end
        checks++; if (io_uop_payload !== PAY_A) begin errors++; $display("FAIL wseq_payload got %h exp %h", io_uop_payload, PAY_A); end
      end
      if (c == 7) begin
        checks++; if (io_will_be_valid !== 1'b0) begin errors++; $display("FAIL wseq_wbv got %b exp 0", io_will_be_valid); end
      end
    end
  endtask

  task automatic test_same_cycle_wakeup();
    next_cycle();
    enq(7'd12, 7'd13, 1, 0, 0, '0);
    wake(3, 7'd12);
    wake(1, 7'd40);
    next_cycle(); #2;
    checks++; if (io_request !== 1'b1) begin errors++; $display("FAIL scw_request got %b exp 1", io_request); end
    io_grant = 1;
    next_cycle(); #2;
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL scw_drop got %b exp 0", io_valid); end
  endtask

  task automatic test_two_part();
    next_cycle();
    enq(7'd20, 7'd21, 0, 1, 1, '0);
    next_cycle(); #2;
    checks++; if ({io_request, io_iss_part} !== 2'b10) begin errors++; $display("FAIL tp_part0 got %b exp 10", {io_request, io_iss_part}); end
    io_grant = 1; #1;
    checks++; if (io_will_be_valid !== 1'b1) begin errors++; $display("FAIL tp_wbv0 got %b exp 1", io_will_be_valid); end
    next_cycle();
    wake(1, 7'd21); #2;
    checks++; if ({io_valid, io_request, io_iss_part} !== 3'b101) begin errors++; $display("FAIL tp_wait got %b exp 101", {io_valid, io_request, io_iss_part}); end
    next_cycle(); #2;
    checks++; if ({io_request, io_iss_part} !== 2'b11) begin errors++; $display("FAIL tp_part1 got %b exp 11", {io_request, io_iss_part}); end
    io_grant = 1; #1;
    checks++; if (io_will_be_valid !== 1'b0) begin errors++; $display("FAIL tp_wbv1 got %b exp 0", io_will_be_valid); end
    next_cycle(); #2;
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL tp_done got %b exp 0", io_valid); end
  endtask

  task automatic test_branch();
    next_cycle();
    enq(7'd1, 7'd2, 0, 0, 0, 20'h00013);
    io_brupdate_resolve_mask = 20'h00001;
    next_cycle(); #2;
    checks++; if (io_uop_br_mask !== 20'h00012) begin errors++; $display("FAIL br_enq_mask got %h exp 00012", io_uop_br_mask); end
    io_brupdate_resolve_mask = 20'h00002; #1;
    checks++; if (io_uop_br_mask !== 20'h00010) begin errors++; $display("FAIL br_resolve got %h exp 00010", io_uop_br_mask); end
    checks++; if (io_request !== 1'b1) begin errors++; $display("FAIL br_request got %b exp 1", io_request); end
    next_cycle(); #2;
    checks++; if (io_uop_br_mask !== 20'h00010) begin errors++; $display("FAIL br_held got %h exp 00010", io_uop_br_mask); end
    io_brupdate_mispredict_mask = 20'h00004; #1;
    checks++; if ({io_request, io_will_be_valid} !== 2'b11) begin errors++; $display("FAIL br_miss_other got %b exp 11", {io_request, io_will_be_valid}); end
    io_brupdate_mispredict_mask = 20'h00010; #1;
    checks++; if ({io_request, io_will_be_valid} !== 2'b00) begin errors++; $display("FAIL br_mispredict got %b exp 00", {io_request, io_will_be_valid}); end
    next_cycle(); #2;
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL br_drop got %b exp 0", io_valid); end
  endtask

  task automatic test_kill_grant();
    next_cycle();
    enq(7'd8, 7'd9, 0, 0, 1, '0);
    next_cycle(); #2;
    checks++; if (io_request !== 1'b1) begin errors++; $display("FAIL kg_request got %b exp 1", io_request); end
    io_kill = 1; io_grant = 1; #1;
    checks++; if ({io_request, io_will_be_valid} !== 2'b00) begin errors++; $display("FAIL kg_gate got %b exp 00", {io_request, io_will_be_valid}); end
    next_cycle(); #2;
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL kg_drop got %b exp 0", io_valid); end
  endtask

  task automatic test_clear();
    next_cycle();
    enq(7'd10, 7'd11, 1, 1, 0, '0);
    next_cycle(); #2;
    io_clear = 1; #1;
    checks++; if ({io_valid, io_will_be_valid} !== 2'b10) begin errors++; $display("FAIL clr_wbv got %b exp 10", {io_valid, io_will_be_valid}); end
    next_cycle(); #2;
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL clr_drop got %b exp 0", io_valid); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    enq(7'd14, 7'd15, 0, 0, 0, '0);
    next_cycle(); #2;
    io_grant = 1;
    enq(7'd30, 7'd31, 1, 0, 0, 20'h00100);
    next_cycle(); #2;
    checks++; if ({io_valid, io_request} !== 2'b10) begin errors++; $display("FAIL b2b_state got %b exp 10", {io_valid, io_request}); end
    checks++; if ({io_uop_prs1, io_uop_br_mask} !== {7'd30, 20'h00100}) begin
      errors++; $display("FAIL b2b_fields got %h exp %h", {io_uop_prs1, io_uop_br_mask}, {7'd30, 20'h00100}); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    enq(7'd7, 7'd6, 0, 0, 1, 20'h00005);
    next_cycle(); #2;
    checks++; if (io_valid !== 1'b1) begin errors++; $display("FAIL rm_valid got %b exp 1", io_valid); end
    rst = 1;
    next_cycle(); #2;
    checks++; if ({io_valid, io_request, io_will_be_valid, io_iss_part} !== 4'b0000) begin
      errors++; $display("FAIL rm_ctrl got %b exp 0000", {io_valid, io_request, io_will_be_valid, io_iss_part}); end
    checks++; if ({io_uop_prs1, io_uop_prs2, io_uop_pdst, io_uop_br_mask, io_uop_payload} !== '0) begin
      errors++; $display("FAIL rm_fields got %h exp 0", {io_uop_prs1, io_uop_prs2, io_uop_pdst, io_uop_br_mask, io_uop_payload}); end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_wakeup_seq();
    test_same_cycle_wakeup();
    test_two_part();
    test_branch();
    test_kill_grant();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
